// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//   Shared definitions for the FIFO family, used by both the single-clock and
//   the dual-clock FIFO. It holds:
//     - default word width and depth, so the FIFO variants agree out of the box
//     - helpers that size the address and pointer fields for a given depth
//     - the status flag bundle and the function that derives it from a level
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Defaults shared with the dual-clock FIFO.
  localparam int FIFO_DEF_DATA_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH      = 16;

  // Address width for a memory of 'depth' entries. A depth of 1 still needs a
  // one-bit address so that vector declarations stay legal.
  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer width: the address plus one wrap bit. With the wrap bit, equal
  // addresses can be told apart as "empty" (same wrap) or "full" (wrap differs).
  function automatic int fifo_ptr_w(input int depth);
    return fifo_addr_w(depth) + 1;
  endfunction

  // Width constants for the default configuration.
  localparam int FIFO_DEF_ADDR_W  = fifo_addr_w(FIFO_DEF_DEPTH);
  localparam int FIFO_DEF_PTR_W   = FIFO_DEF_ADDR_W + 1;
  localparam int FIFO_DEF_LEVEL_W = FIFO_DEF_PTR_W;

  // Occupancy-derived status flags. They are registered as one group so that
  // they always describe the same level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Derive the status flags from an occupancy level.
  function automatic fifo_flags_t fifo_calc_flags(input int lvl,
                                                  input int depth,
                                                  input int af_level,
                                                  input int ae_level);
    fifo_flags_t f;
    f.full         = (lvl == depth);
    f.empty        = (lvl == 0);
    f.almost_full  = (lvl >= af_level);
    f.almost_empty = (lvl <= ae_level);
    return f;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//
// Purpose:
//   Storage array for sync_fifo_param: DEPTH words of DATA_WIDTH bits, with one
//   write port and one read port. The array is named fifo_mem so it can be
//   probed hierarchically.
//
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : registered read. rd_data loads fifo_mem[rd_addr] on a clock edge
//               where rd_en is high, and holds otherwise. It resets to 0.
//   defined   : combinational read. rd_data always shows fifo_mem[rd_addr], so
//               no reset and no read enable are needed.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (registered read only)
//   rd_en    in   read strobe (registered read only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int ADDR_W     = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  reset,
  input  logic                  rd_en,
`endif
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Contents are never reset. Emptiness is tracked by the pointers in the
  // parent, so stale words are unreachable.
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is visible as soon as it has been written.
  assign rd_data = fifo_mem[rd_addr];
`else
  // A simultaneous write to the same address (only possible when the FIFO is
  // full) returns the old word, which is the one being popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= fifo_mem[rd_addr];
    end
  end
`endif

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Purpose:
//   Parametrised single-clock FIFO. Provides:
//     - fill level output and full/empty flags
//     - programmable almost-full/almost-empty thresholds
//     - sticky overflow/underflow error flags
//     - synchronous flush
//   All flags are registered and computed from the next-state level.
//
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : standard mode. A read accepted at an edge loads data_out at
//               that edge, and data_out holds until the next accepted read.
//   defined   : first-word fall-through. data_out shows the head word whenever
//               the FIFO is not empty (0 when empty), and read_enable pops it.
//
// Handshake: write_enable and read_enable are requests sampled on every rising
// edge, and !wr_full and !rd_empty act as the matching readies. On the write
// side, wr_full does not block a write when a read is accepted on the same
// edge. A request with no matching ready is rejected and sets the sticky error
// flag for its side. Flush overrides both requests and raises no error.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   flush         in   synchronous pointer clear
//   write_enable  in   push request
//   data_in       in   write data
//   read_enable   in   pop request
//   data_out      out  read data
//   wr_full       out  level == DEPTH
//   rd_empty      out  level == 0
//   almost_full   out  level >= AF_LEVEL
//   almost_empty  out  level <= AE_LEVEL
//   level         out  occupancy, 0..DEPTH
//   overflow      out  sticky: write rejected
//   underflow     out  sticky: read rejected
//   clear_err     in   synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   write_enable,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   read_enable,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   wr_full,
  output logic                   rd_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clear_err
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);
  localparam int PTR_W  = fifo_ptr_w(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  fifo_flags_t           flags;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  udf_set;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [PTR_W-1:0]      level_nxt;
  fifo_flags_t           flags_nxt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // ---------------------------------------------------------------------------
  // Acceptance, pointer and flag computation
  // ---------------------------------------------------------------------------
  always_comb begin
    // The read is decided first, because a full FIFO can still take a write
    // when a word leaves on the same edge.
    rd_acc  = read_enable  && !rd_empty && !flush;
    wr_acc  = write_enable && !flush && (!wr_full || rd_acc);

    // Requests dropped by flush are not errors.
    ovf_set = write_enable && !flush && !wr_acc;
    udf_set = read_enable  && !flush && !rd_acc;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
      rd_ptr_nxt = rd_ptr + PTR_W'(rd_acc);
    end

    // Modulo-2^PTR_W difference. This stays correct across the wrap bit.
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    flags_nxt = fifo_calc_flags(int'(level_nxt), DEPTH, AF_LEVEL, AE_LEVEL);

    // A new error on the same edge as clear_err takes priority.
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (clear_err) begin
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end
    if (ovf_set) begin
      overflow_nxt = 1'b1;
    end
    if (udf_set) begin
      underflow_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      flags     <= fifo_calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      flags     <= flags_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  assign wr_full      = flags.full;
  assign rd_empty     = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .reset   (reset),
    .rd_en   (rd_acc),
`endif
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The memory location under rd_ptr is stale while the FIFO is empty, so it
  // is masked to 0.
  assign data_out = rd_empty ? '0 : mem_rd_data;
`else
  assign data_out = mem_rd_data;
`endif

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk          = 1'b0;
  logic          reset        = 1'b0;
  logic          flush        = 1'b0;
  logic          write_enable = 1'b0;
  logic          read_enable  = 1'b0;
  logic          clear_err    = 1'b0;
  logic [DW-1:0] data_in      = '0;
  logic [DW-1:0] data_out;
  logic          wr_full;
  logic          rd_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .write_enable (write_enable),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .wr_full      (wr_full),
    .rd_empty     (rd_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_err    (clear_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];    // words expected on data_out, in order
  logic [DW-1:0] model_q[$];  // reference FIFO contents
  logic          pend     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_pop();
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rd_unexpected: actual=%0d expected=none", data_out);
    end else begin
      e = exp_q.pop_front();
      check("rd_data", 32'(data_out), 32'(e));
    end
  endtask

  // Monitor: sampled mid-cycle, so inputs for the coming edge and outputs from
  // the previous edge are both stable.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else begin
`ifdef SYNC_FIFO_FWFT_EN
        if (read_enable && !rd_empty) compare_pop();
`else
        if (pend) compare_pop();
        pend = read_enable && !rd_empty;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic we, input logic [DW-1:0] din, input logic re,
                       input logic fl, input logic ce);
    bit rd_ok;
    bit wr_ok;
    write_enable = we;
    data_in      = din;
    read_enable  = re;
    flush        = fl;
    clear_err    = ce;
    rd_ok = re && !fl && (model_q.size() > 0);
    wr_ok = we && !fl && ((model_q.size() < DEPTH) || rd_ok);
    if (fl) begin
      model_q.delete();
    end else begin
      if (rd_ok) exp_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(din);
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    flush        = 1'b0;
    clear_err    = 1'b0;
    data_in      = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    #12;
    check("rst_level",        32'(level),        0);
    check("rst_rd_empty",     32'(rd_empty),     1);
    check("rst_almost_empty", 32'(almost_empty), 1);
    check("rst_wr_full",      32'(wr_full),      0);
    check("rst_almost_full",  32'(almost_full),  0);
    check("rst_data_out",     32'(data_out),     0);
    check("rst_overflow",     32'(overflow),     0);
    check("rst_underflow",    32'(underflow),    0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    check("idle_level",        32'(level),        0);
    check("idle_rd_empty",     32'(rd_empty),     1);
    check("idle_almost_empty", 32'(almost_empty), 1);
    check("idle_data_out",     32'(data_out),     0);

    // Partial fill, one pop, then an asynchronous reset at level 5.
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(11 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("midfill_level", 32'(level), 5);
    reset = 1'b0;
    model_q.delete();
    #1;
    check("async_rst_level",        32'(level),        0);
    check("async_rst_rd_empty",     32'(rd_empty),     1);
    check("async_rst_almost_empty", 32'(almost_empty), 1);
    check("async_rst_almost_full",  32'(almost_full),  0);
    check("async_rst_data_out",     32'(data_out),     0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 10..160 and check the flags after every write.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, DW'(10 * i), 1'b0, 1'b0, 1'b0);
      check("fill_level",        32'(level),        32'(i));
      check("fill_wr_full",      32'(wr_full),      32'(i == DEPTH));
      check("fill_almost_full",  32'(almost_full),  32'(i >= 14));
      check("fill_almost_empty", 32'(almost_empty), 32'(i <= 2));
    end
    drive(1'b1, 8'd170, 1'b0, 1'b0, 1'b0);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_level", 32'(level),    16);
    check("ovf_mem15", 32'(dut.u_mem.fifo_mem[15]), 160);

    // Drain. The monitor checks 10..160 in order.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain_level", 32'(level), 32'(DEPTH - i));
    end
    check("drain_rd_empty", 32'(rd_empty), 1);
    idle(1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf_flag", 32'(underflow), 1);
    idle(1);
`ifdef SYNC_FIFO_FWFT_EN
    check("udf_data_zero", 32'(data_out), 0);
`else
    check("udf_data_hold", 32'(data_out), 160);
`endif
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("clr_overflow",  32'(overflow),  0);
    check("clr_underflow", 32'(underflow), 0);

    // Full with a simultaneous read and write.
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
    check("fullrw_level",     32'(level),     16);
    check("fullrw_wr_full",   32'(wr_full),   1);
    check("fullrw_overflow",  32'(overflow),  0);
    check("fullrw_underflow", 32'(underflow), 0);
    for (int i = 1; i <= DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
`ifndef SYNC_FIFO_FWFT_EN
    check("fullrw_last_200", 32'(data_out), 200);
`endif

    // Flush with a simultaneous write.
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(50 + i), 1'b0, 1'b0, 1'b0);
    check("prefl_level", 32'(level), 8);
    drive(1'b1, 8'd99, 1'b0, 1'b1, 1'b0);
    check("flush_level",     32'(level),     0);
    check("flush_rd_empty",  32'(rd_empty),  1);
    check("flush_overflow",  32'(overflow),  0);
    check("flush_underflow", 32'(underflow), 0);

    // Empty with a simultaneous read and write.
    drive(1'b1, 8'd77, 1'b1, 1'b0, 1'b0);
    check("emptyrw_underflow", 32'(underflow), 1);
    check("emptyrw_overflow",  32'(overflow),  0);
    check("emptyrw_level",     32'(level),     1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // A new error on the same edge as clear_err wins.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("clr_vs_err", 32'(underflow), 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("clr_after",  32'(underflow), 0);

`ifdef SYNC_FIFO_FWFT_EN
    drive(1'b1, 8'd42, 1'b0, 1'b0, 1'b0);
    check("fwft_data",     32'(data_out), 42);
    check("fwft_rd_empty", 32'(rd_empty), 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("fwft_pop_empty", 32'(rd_empty), 1);
    check("fwft_pop_zero",  32'(data_out), 0);
`endif

    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_fifo_param
